// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Write-side master for instruction_memory. Parses a byte stream framed as
// a 2-byte little-endian word count N followed by N little-endian 32-bit
// words, and writes each word to consecutive imem addresses starting at
// BASE_ADDR. The core is held in reset (o_cpu_hold) until a load completes.
//
// Optional feature (macro IMEM_LOADER_CSUM_EN): one trailing checksum byte,
// the XOR of all header and data bytes, is accepted after the last word;
// o_csum_err flags a mismatch. Without the macro o_csum_err is tied 0.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     1-cycle pulse, begins a load (honoured only when idle/done)
//   i_in_valid  stream byte valid
//   i_in_byte   stream byte
//   o_in_ready  byte accepted this cycle when i_in_valid is also high
//   o_wr        imem write strobe, one cycle per stored word
//   o_addr      imem byte address
//   o_wdata     imem write data
//   o_cpu_hold  core held in reset while high
//   o_busy      load in progress
//   o_done      last load completed, held until next start
//   o_overflow  N exceeded MEM_SIZE, sticky until next start
//   o_csum_err  checksum mismatch, sticky until next start
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned WIDTH1    = 32,
    parameter int unsigned MEM_SIZE  = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_byte,
    output logic              o_in_ready,
    output logic              o_wr,
    output logic [WIDTH1-1:0] o_addr,
    output logic [WIDTH1-1:0] o_wdata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic              o_csum_err
);

    typedef enum logic [2:0] {
        StIdle, StHdr, StData, StWrite, StCsum, StDone
    } state_t;

    state_t            r_state;
    logic [1:0]        r_byte_idx;
    logic [15:0]       r_nwords;
    logic [15:0]       r_word_idx;
    logic [23:0]       r_shift;     // b2,b1,b0 of the word being assembled
    logic              r_in_ready;
    logic              r_wr;
    logic [WIDTH1-1:0] r_addr;
    logic [WIDTH1-1:0] r_wdata;
    logic              r_cpu_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;

    logic              w_accept;
    logic              w_start_ok;
    logic [15:0]       w_n;
    logic [31:0]       w_word;
    logic [15:0]       w_next_idx;
    logic              w_in_range;
    logic [WIDTH1-1:0] w_addr;

    assign w_accept   = i_in_valid & r_in_ready;
    assign w_start_ok = i_start & ((r_state == StIdle) | (r_state == StDone));
    assign w_n        = {i_in_byte, r_nwords[7:0]};
    assign w_word     = {i_in_byte, r_shift};
    assign w_next_idx = r_word_idx + 16'd1;
    assign w_in_range = (32'(r_word_idx) < MEM_SIZE);
    assign w_addr     = WIDTH1'(BASE_ADDR) + (WIDTH1'(r_word_idx) << 2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_byte_idx <= 2'd0;
            r_nwords   <= 16'd0;
            r_word_idx <= 16'd0;
            r_shift    <= 24'd0;
            r_in_ready <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= WIDTH1'(BASE_ADDR);
            r_wdata    <= '0;
            r_cpu_hold <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (w_start_ok) begin
                        r_state    <= StHdr;
                        r_byte_idx <= 2'd0;
                        r_word_idx <= 16'd0;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                StHdr: begin
                    if (w_accept) begin
                        if (r_byte_idx == 2'd0) begin
                            r_nwords[7:0] <= i_in_byte;
                            r_byte_idx    <= 2'd1;
                        end else begin
                            r_nwords   <= w_n;
                            r_byte_idx <= 2'd0;
                            if (w_n != 16'd0) begin
                                r_state <= StData;
                            end else begin
`ifdef IMEM_LOADER_CSUM_EN
                                r_state    <= StCsum;
`else
                                r_state    <= StDone;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_cpu_hold <= 1'b0;
`endif
                            end
                        end
                    end
                end
                StData: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state    <= StWrite;
                            r_in_ready <= 1'b0;
                            // Out-of-range words are consumed but never written.
                            if (w_in_range) begin
                                r_wr    <= 1'b1;
                                r_addr  <= w_addr;
                                r_wdata <= WIDTH1'(w_word);
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end else begin
                            r_shift <= {i_in_byte, r_shift[23:8]};
                        end
                    end
                end
                StWrite: begin
                    r_word_idx <= w_next_idx;
                    if (w_next_idx != r_nwords) begin
                        r_state    <= StData;
                        r_in_ready <= 1'b1;
                    end else begin
`ifdef IMEM_LOADER_CSUM_EN
                        r_state    <= StCsum;
                        r_in_ready <= 1'b1;
`else
                        r_state    <= StDone;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
`endif
                    end
                end
                StCsum: begin
                    if (w_accept) begin
                        r_state    <= StDone;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] r_csum;
    logic       r_csum_err;

    // Running XOR of header and data bytes; the CSUM byte itself is compared.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum     <= 8'd0;
            r_csum_err <= 1'b0;
        end else if (w_start_ok) begin
            r_csum     <= 8'd0;
            r_csum_err <= 1'b0;
        end else if (w_accept) begin
            if (r_state == StCsum) begin
                r_csum_err <= (i_in_byte != r_csum);
            end else begin
                r_csum <= r_csum ^ i_in_byte;
            end
        end
    end

    assign o_csum_err = r_csum_err;
`else
    assign o_csum_err = 1'b0;
`endif

    assign o_in_ready = r_in_ready;
    assign o_wr       = r_wr;
    assign o_addr     = r_addr;
    assign o_wdata    = r_wdata;
    assign o_cpu_hold = r_cpu_hold;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader (MEM_SIZE=2 so overflow is reachable).
// Frames are table-driven; reset-mid-load and bad-checksum are hand sequences.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        csum_err;

    int tests  = 0;
    int failed = 0;

    imem_loader #(
        .WIDTH1    (32),
        .MEM_SIZE  (2),
        .BASE_ADDR (0)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_in_valid (in_valid),
        .i_in_byte  (in_byte),
        .o_in_ready (in_ready),
        .o_wr       (wr),
        .o_addr     (addr),
        .o_wdata    (wdata),
        .o_cpu_hold (cpu_hold),
        .o_busy     (busy),
        .o_done     (done),
        .o_overflow (overflow),
        .o_csum_err (csum_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every cycle with wr high; a multi-cycle strobe shows up as extra entries.
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            log_a.push_back(addr);
            log_d.push_back(wdata);
        end
    end

    typedef struct packed {
        int               nb;
        logic [0:15][7:0] b;
        int               stall;
        bit               start_mid;
        int               nwr;
        logic [0:2][31:0] ea;
        logic [0:2][31:0] ed;
        bit               eovf;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            tests++;
            failed++;
            $display("FAIL ready_timeout: in_ready never rose for byte %h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("done_wait", {31'd0, done}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input bit bad_csum);
        int         base = log_a.size();
        logic [7:0] x    = 8'h00;
        pulse_start();
        for (int i = 0; i < v.nb; i++) begin
            repeat (v.stall) @(posedge clk);
            send_byte(v.b[i]);
            x = x ^ v.b[i];
            if (v.start_mid && i == 2) pulse_start();
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(bad_csum ? ~x : x);
`endif
        wait_done();
        repeat (2) @(negedge clk);
        check("wr_count", 32'(log_a.size() - base), 32'(v.nwr));
        for (int j = 0; j < v.nwr; j++) begin
            if (base + j < log_a.size()) begin
                check("wr_addr", log_a[base + j], v.ea[j]);
                check("wr_data", log_d[base + j], v.ed[j]);
            end
        end
        if (v.nwr > 0) begin
            check("addr_hold", addr, v.ea[v.nwr - 1]);
            check("wdata_hold", wdata, v.ed[v.nwr - 1]);
        end
        check("done", {31'd0, done}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("cpu_hold_end", {31'd0, cpu_hold}, 32'd0);
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        check("overflow", {31'd0, overflow}, {31'd0, v.eovf});
`ifdef IMEM_LOADER_CSUM_EN
        check("csum_err", {31'd0, csum_err}, {31'd0, bad_csum});
`else
        check("csum_err", {31'd0, csum_err}, 32'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;

        // Frame: N=2, words 0x00100513, 0x00200513.
        vecs[0].nb        = 10;
        vecs[0].b         = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                             8'h13, 8'h05, 8'h20, 8'h00, 48'h0};
        vecs[0].stall     = 0;
        vecs[0].start_mid = 1'b0;
        vecs[0].nwr       = 2;
        vecs[0].ea        = {32'h0, 32'h4, 32'h0};
        vecs[0].ed        = {32'h0010_0513, 32'h0020_0513, 32'h0};
        vecs[0].eovf      = 1'b0;
        // Same frame, 3 idle cycles between bytes, stray start mid-load.
        vecs[1]           = vecs[0];
        vecs[1].stall     = 3;
        vecs[1].start_mid = 1'b1;
        // Empty frame.
        vecs[2].nb        = 2;
        vecs[2].b         = {8'h00, 8'h00, 112'h0};
        vecs[2].stall     = 0;
        vecs[2].start_mid = 1'b0;
        vecs[2].nwr       = 0;
        vecs[2].ea        = '0;
        vecs[2].ed        = '0;
        vecs[2].eovf      = 1'b0;
        // N=3 into MEM_SIZE=2: third word consumed without a write.
        vecs[3].nb        = 14;
        vecs[3].b         = {8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                             8'h66, 8'h77, 8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 16'h0};
        vecs[3].stall     = 0;
        vecs[3].start_mid = 1'b0;
        vecs[3].nwr       = 2;
        vecs[3].ea        = {32'h0, 32'h4, 32'h0};
        vecs[3].ed        = {32'h4433_2211, 32'h8877_6655, 32'h0};
        vecs[3].eovf      = 1'b1;

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        check("idle_wr_count", 32'(log_a.size()), 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_addr", addr, 32'h0);
        check("idle_wdata", wdata, 32'h0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0);

        // Start from DONE, then reset after 5 bytes (partial word).
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("start_in_ready", {31'd0, in_ready}, 32'd1);
        check("start_done_clr", {31'd0, done}, 32'd0);
        check("start_ovf_clr", {31'd0, overflow}, 32'd0);
        base = log_a.size();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'h10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wr", {31'd0, wr}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_wr", 32'(log_a.size() - base), 32'd0);
        run_vec(vecs[0], 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
        run_vec(vecs[0], 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
